// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch unit: FSM states, the NOP
// instruction word and the canonical 32-bit prefetch entry layout.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        HALT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned ENTRY_XLEN = 32;

    typedef struct packed {
        logic [ENTRY_XLEN-1:0] pc;
        logic [ENTRY_XLEN-1:0] instr;
        logic                  misalign;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head, occupancy count and a synchronous
// clear that may load one entry in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        empty    = (count == '0);
        full     = (count == CW'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            // Clear wins over pop; a push alongside clear becomes the sole entry.
            rd_ptr <= '0;
            wr_ptr <= push ? bump('0) : '0;
            count  <= push ? CW'(1) : '0;
        end else begin
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear ? push : do_push) mem[clear ? '0 : wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, credit-limited imem requests, prefetch FIFO to decode.
// FETCH_MISALIGN_CHECK_EN adds dec_misalign and halts on misaligned redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            dec_misalign
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned EW = 2 * XLEN + 1;

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] fetch_pc, fetch_pc_next, redirect_target;
    logic [OW-1:0]   outstanding, outstanding_next;
    logic [OW-1:0]   drop_cnt, drop_cnt_next;
    logic [SW-1:0]   credit_used;
    logic            req_valid, req_fire, rsp_keep, rsp_drop, misalign_redirect;

    logic [CW-1:0]   fifo_count;
    logic [EW-1:0]   fifo_in, fifo_head;
    logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [OW-1:0]   tag_count;
    logic [XLEN-1:0] tag_head;
    logic            tag_push, tag_pop, tag_empty, tag_full;

    always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
        redirect_target   = redirect_pc;
`else
        misalign_redirect = 1'b0;
        redirect_target   = redirect_pc & ~XLEN'(3);
`endif
        credit_used = SW'(fifo_count) + SW'(outstanding);
        req_valid   = !rst && (state == RUN) && (credit_used < SW'(DEPTH))
                      && (outstanding < OW'(MAX_OUTSTANDING));
        req_fire    = req_valid && imem_req_ready;
        rsp_keep    = imem_rsp_valid && (state == RUN) && (drop_cnt == '0);
        rsp_drop    = imem_rsp_valid && (drop_cnt != '0);

        outstanding_next = outstanding + OW'(req_fire) - OW'(rsp_keep || rsp_drop);
        drop_cnt_next    = drop_cnt - OW'(rsp_drop);
        fetch_pc_next    = req_fire ? fetch_pc + XLEN'(4) : fetch_pc;
        state_next       = state;
        if (state == FLUSH && drop_cnt_next == '0) state_next = RUN;

        // In FLUSH drop_cnt already equals outstanding, so a repeat redirect keeps it.
        if (redirect_valid) begin
            fetch_pc_next = redirect_target;
            drop_cnt_next = outstanding_next;
            if (misalign_redirect)            state_next = HALT;
            else if (outstanding_next != '0)  state_next = FLUSH;
            else                              state_next = RUN;
        end

        tag_push  = req_fire && !redirect_valid;
        tag_pop   = rsp_keep;
        fifo_push = redirect_valid ? misalign_redirect : rsp_keep;
        fifo_in   = misalign_redirect ? {redirect_pc, XLEN'(NOP_INSTR), 1'b1}
                                      : {tag_head, imem_rsp_data, 1'b0};

        imem_req_valid = req_valid;
        imem_req_addr  = fetch_pc;
        dec_valid      = !fifo_empty;
        fifo_pop       = dec_valid && dec_ready;
        dec_pc         = dec_valid ? fifo_head[EW-1 -: XLEN] : '0;
        dec_instr      = dec_valid ? fifo_head[XLEN:1] : '0;
        dec_pc_plus4   = dec_valid ? fifo_head[EW-1 -: XLEN] + XLEN'(4) : '0;
`ifdef FETCH_MISALIGN_CHECK_EN
        dec_misalign   = dec_valid && fifo_head[0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
        end
    end

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_prefetch_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (tag_push),
        .push_data (fetch_pc),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .empty     (tag_empty),
        .full      (tag_full),
        .count     (tag_count)
    );

    // Protocol invariants: the credit rule keeps both queues in bounds.
    assert property (@(posedge clk) disable iff (rst) rsp_keep |-> !fifo_full);
    assert property (@(posedge clk) disable iff (rst) rsp_keep |-> !tag_empty);
    assert property (@(posedge clk) disable iff (rst) tag_push |-> !tag_full);
    assert property (@(posedge clk) disable iff (rst) (state == RUN) |-> (tag_count == outstanding));
`ifndef FETCH_MISALIGN_CHECK_EN
    assert property (@(posedge clk) disable iff (rst) dec_valid |-> !fifo_head[0]);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc_plus4;
    logic        dec_misalign;

    fetch_unit #(
        .XLEN            (32),
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .dec_pc_plus4   (dec_pc_plus4)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .dec_misalign   (dec_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mem_req_t;

    typedef struct {
        logic        rst, rr, dr, rdv;
        logic [31:0] rpc;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_dv;
        logic [31:0] e_pc;
    } vec_t;

    mem_req_t memq[$];
    vec_t     tbl[$];
    int       lat;
    int       cyc;
    int       checks;
    int       passes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one cycle's inputs at the falling edge; memory answers lat cycles after acceptance.
    task automatic step(input logic r, input logic rr, input logic dr, input logic rdv,
                        input logic [31:0] rpc);
        @(negedge clk);
        cyc++;
        rst            = r;
        imem_req_ready = rr;
        dec_ready      = dr;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (r) memq.delete();
        else if (memq.size() > 0 && memq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~memq[0].addr;
            void'(memq.pop_front());
        end
        #1;
        if (!r && imem_req_valid && imem_req_ready)
            memq.push_back('{due: cyc + lat, addr: imem_req_addr});
    endtask

    task automatic reset_and_check(input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk({tag, ".rst.req_valid"}, {31'b0, imem_req_valid}, 32'h0);
        chk({tag, ".rst.req_addr"}, imem_req_addr, 32'h0);
        chk({tag, ".rst.dec_valid"}, {31'b0, dec_valid}, 32'h0);
        chk({tag, ".rst.dec_pc"}, dec_pc, 32'h0);
        chk({tag, ".rst.dec_pc_plus4"}, dec_pc_plus4, 32'h0);
    endtask

    function automatic void add(input int r, input int rr, input int dr, input int rdv,
                                input logic [31:0] rpc, input int erv, input logic [31:0] ea,
                                input int edv, input logic [31:0] ep);
        vec_t v;
        v.rst = (r != 0);  v.rr = (rr != 0);  v.dr = (dr != 0);  v.rdv = (rdv != 0);
        v.rpc = rpc;  v.e_rv = (erv != 0);  v.e_addr = ea;  v.e_dv = (edv != 0);  v.e_pc = ep;
        tbl.push_back(v);
    endfunction

    initial begin
        int fires;
        int got;
        checks = 0;  passes = 0;  cyc = 0;  lat = 1;
        rst = 1'b1;  redirect_valid = 1'b0;  redirect_pc = '0;
        imem_req_ready = 1'b0;  imem_rsp_valid = 1'b0;  imem_rsp_data = '0;  dec_ready = 1'b0;

        // Streaming, decode backpressure, request stall for 5 cycles, redirect with one in flight.
        //    rst rr dr rdv rpc       rv addr      dv dec_pc
        add(1, 0, 0, 0, 0,        0, 32'h000,  0, 32'h000);
        add(0, 1, 1, 0, 0,        1, 32'h000,  0, 32'h000);
        add(0, 1, 1, 0, 0,        1, 32'h004,  0, 32'h000);
        add(0, 1, 1, 0, 0,        1, 32'h008,  1, 32'h000);
        add(0, 1, 1, 0, 0,        1, 32'h00C,  1, 32'h004);
        add(0, 1, 0, 0, 0,        1, 32'h010,  1, 32'h008);
        add(0, 1, 0, 0, 0,        1, 32'h014,  1, 32'h008);
        add(0, 1, 0, 0, 0,        0, 32'h018,  1, 32'h008);
        add(0, 1, 0, 0, 0,        0, 32'h018,  1, 32'h008);
        add(0, 1, 0, 0, 0,        0, 32'h018,  1, 32'h008);
        add(0, 1, 1, 0, 0,        0, 32'h018,  1, 32'h008);
        add(0, 1, 1, 0, 0,        1, 32'h018,  1, 32'h00C);
        add(0, 1, 1, 0, 0,        1, 32'h01C,  1, 32'h010);
        add(0, 0, 1, 0, 0,        1, 32'h020,  1, 32'h014);
        add(0, 0, 1, 0, 0,        1, 32'h020,  1, 32'h018);
        add(0, 0, 1, 0, 0,        1, 32'h020,  1, 32'h01C);
        add(0, 0, 1, 0, 0,        1, 32'h020,  0, 32'h000);
        add(0, 0, 1, 0, 0,        1, 32'h020,  0, 32'h000);
        add(0, 1, 1, 0, 0,        1, 32'h020,  0, 32'h000);
        add(0, 1, 1, 0, 0,        1, 32'h024,  0, 32'h000);
        add(0, 1, 1, 1, 32'h100,  1, 32'h028,  1, 32'h020);
        add(0, 1, 1, 0, 0,        0, 32'h100,  0, 32'h000);
        add(0, 1, 1, 0, 0,        1, 32'h100,  0, 32'h000);
        add(0, 1, 1, 0, 0,        1, 32'h104,  0, 32'h000);
        add(0, 1, 1, 0, 0,        1, 32'h108,  1, 32'h100);
        add(0, 1, 1, 0, 0,        1, 32'h10C,  1, 32'h104);

        for (int unsigned i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].rr, tbl[i].dr, tbl[i].rdv, tbl[i].rpc);
            chk($sformatf("v%0d.req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].e_rv});
            chk($sformatf("v%0d.req_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("v%0d.dec_valid", i), {31'b0, dec_valid}, {31'b0, tbl[i].e_dv});
            chk($sformatf("v%0d.dec_pc", i), dec_pc, tbl[i].e_pc);
            chk($sformatf("v%0d.dec_instr", i), dec_instr, tbl[i].e_dv ? ~tbl[i].e_pc : 32'h0);
            chk($sformatf("v%0d.dec_pc_plus4", i), dec_pc_plus4,
                tbl[i].e_dv ? tbl[i].e_pc + 32'h4 : 32'h0);
        end

        // Decode stalled from reset: exactly DEPTH requests, then issue resumes on release.
        lat = 1;
        reset_and_check("fill");
        fires = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            if (imem_req_valid) fires++;
        end
        chk("fill.requests", fires, 4);
        chk("fill.req_valid_off", {31'b0, imem_req_valid}, 32'h0);
        chk("fill.dec_pc", dec_pc, 32'h0);
        got = 0;
        for (int unsigned i = 0; i < 4 && got == 0; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            if (imem_req_valid) got = 1;
        end
        chk("fill.resume", got, 1);
        chk("fill.resume_addr", imem_req_addr, 32'h10);

        // Redirect while two requests are in flight (3-cycle memory): both responses dropped.
        lat = 3;
        reset_and_check("flush");
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("flush.addr0", imem_req_addr, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("flush.addr1", imem_req_addr, 32'h4);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
        chk("flush.credit_full", {31'b0, imem_req_valid}, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("flush.no_req_a", {31'b0, imem_req_valid}, 32'h0);
        chk("flush.addr_loaded", imem_req_addr, 32'h100);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("flush.no_req_b", {31'b0, imem_req_valid}, 32'h0);
        chk("flush.no_dec", {31'b0, dec_valid}, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("flush.resume_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("flush.resume_addr", imem_req_addr, 32'h100);
        got = 0;
        for (int unsigned i = 0; i < 8 && got == 0; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            if (dec_valid) got = 1;
        end
        chk("flush.dec_arrives", got, 1);
        chk("flush.first_dec_pc", dec_pc, 32'h100);
        chk("flush.first_dec_instr", dec_instr, ~32'h100);

        // PC wrap at the top of the address space.
        lat = 1;
        reset_and_check("wrap");
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap.addr_top", imem_req_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap.addr_wrapped", imem_req_addr, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap.dec_valid", {31'b0, dec_valid}, 32'h1);
        chk("wrap.dec_pc", dec_pc, 32'hFFFF_FFFC);
        chk("wrap.dec_pc_plus4", dec_pc_plus4, 32'h0);
        chk("wrap.dec_instr", dec_instr, 32'h3);

        reset_and_check("misalign");
`ifdef FETCH_MISALIGN_CHECK_EN
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h102);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("misalign.dec_valid", {31'b0, dec_valid}, 32'h1);
        chk("misalign.dec_pc", dec_pc, 32'h102);
        chk("misalign.dec_instr", dec_instr, 32'h13);
        chk("misalign.flag", {31'b0, dec_misalign}, 32'h1);
        chk("misalign.halt_req", {31'b0, imem_req_valid}, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("misalign.single_entry", {31'b0, dec_valid}, 32'h0);
        chk("misalign.halt_req2", {31'b0, imem_req_valid}, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("misalign.resume_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("misalign.resume_addr", imem_req_addr, 32'h200);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("misalign.resume_dec_pc", dec_pc, 32'h200);
        chk("misalign.resume_flag", {31'b0, dec_misalign}, 32'h0);
`else
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h103);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("align.req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("align.addr_forced", imem_req_addr, 32'h100);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("align.addr_next", imem_req_addr, 32'h104);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("align.dec_pc", dec_pc, 32'h100);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor to the single-cycle fetch stage.
- Owns the PC register and issues requests to an instruction memory with latency through a valid/ready request port and an in-order response port.
- Buffers fetched {pc, instr} pairs in a prefetch FIFO that drains to decode with valid/ready.
- A redirect (branch, jump or jump-register target, already selected upstream) flushes the FIFO and discards in-flight responses.

Parameters:
- XLEN, 32, width of PC and instruction.
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2).
- MAX_OUTSTANDING, 2, maximum memory requests in flight (1..DEPTH).
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  take redirect this cycle.
- redirect_pc  in  XLEN  redirect target.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address (current fetch PC).
- imem_rsp_valid  in  1  response valid; in order; no backpressure.
- imem_rsp_data  in  XLEN  instruction word.
- dec_valid  out  1  FIFO head valid.
- dec_ready  in  1  decode accepts head.
- dec_pc  out  XLEN  PC of head instruction.
- dec_instr  out  XLEN  head instruction.
- dec_pc_plus4  out  XLEN  dec_pc + 4, modulo 2^XLEN.

Behaviour:
- Reset (async, active-high):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0; state = RUN.
  - Outputs: imem_req_valid = 0, dec_valid = 0. imem_req_addr follows fetch_pc (RESET_PC). dec_pc, dec_instr and dec_pc_plus4 are 0.
- Request issue in RUN:
  - imem_req_valid = 1 iff (fifo_count + outstanding) < DEPTH and outstanding < MAX_OUTSTANDING.
  - A request is accepted when valid & ready. On acceptance: outstanding += 1; fetch_pc += 4 (wraps modulo 2^XLEN).
  - imem_req_valid and imem_req_addr are held stable until ready.
- Response in RUN, drop_cnt == 0:
  - imem_rsp_valid pushes {pc, data} into the FIFO; outstanding -= 1.
  - The pc for each response comes from an internal in-order tag queue of depth MAX_OUTSTANDING, pushed on request acceptance.
  - The FIFO can never overflow because of the credit rule. A response arriving at a full FIFO is a protocol error, flagged by a simulation assertion.
- Decode side:
  - dec_valid = FIFO non-empty. Pop on dec_valid & dec_ready.
  - Same-cycle push and pop is allowed and leaves the count unchanged. Output is zero-bubble at full throughput: 1 instruction/cycle when memory sustains it.
- Redirect (any state), effective next edge:
  - FIFO cleared; tag queue cleared; fetch_pc = redirect_pc.
  - drop_cnt = outstanding, counted after this cycle's request/response updates.
  - Any request accepted in the redirect cycle counts as outstanding and is dropped.
  - dec_valid is deasserted the next cycle. The FIFO head shown in the redirect cycle may still be popped that cycle.
  - Next state = FLUSH if drop_cnt > 0, else RUN.
- FLUSH:
  - imem_req_valid = 0. Each imem_rsp_valid decrements drop_cnt and outstanding with no push.
  - When drop_cnt reaches 0, go to RUN.
  - A redirect in FLUSH reloads fetch_pc only; drop_cnt is unchanged because no new requests were issued.
- Back-to-back redirects: the last one wins.
- Reset mid-operation: all state is cleared immediately. Memory responses still in flight after reset are the integration's responsibility; memory is reset together with this block.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Extra output port dec_misalign (1 bit).
  - A redirect_pc with bits [1:0] ≠ 0 is not fetched. Instead, a single FIFO entry {redirect_pc, 32'h0000_0013 (NOP)} is enqueued with misalign = 1, and the unit enters a HALT state with no requests.
  - HALT exits only on the next redirect or on reset.
- Undefined:
  - No port.
  - redirect_pc[1:0] is forced to 0 before loading fetch_pc.

Decomposition:
- Package fetch_pkg: state encoding (RUN, FLUSH, HALT), the NOP constant, and the fetch_entry_t struct {pc, instr, misalign}.
- One natural sub-module: sync_fifo (parametrised width/depth, count output), instantiated for the prefetch FIFO and the tag queue.
- The PC+4 adder reuses the existing adder block.

Test Plan:
- Reset, memory with 1-cycle latency, dec_ready = 1 → request addresses 0, 4, 8, 12…. dec_pc sequence 0, 4, 8 with one instruction/cycle after a 2-cycle fill.
- dec_ready = 0 with DEPTH = 4 → exactly 4 requests issued, then imem_req_valid = 0. Releasing dec_ready resumes issue.
- Redirect to 0x100 while 2 requests are outstanding → FLUSH, the 2 responses are dropped, next request addr = 0x100, first dec_pc = 0x100.
- imem_req_ready held low for 5 cycles → imem_req_addr stable; no PC advance.
- fetch_pc = 0xFFFF_FFFC → next request addr 0x0000_0000; dec_pc_plus4 = 0.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 → one entry with dec_misalign = 1 and dec_instr = 0x13, then no requests. Redirect to 0x200 → normal fetch resumes.
